// File: rtl/matrix_mac.sv
// rtl/matrix_mac.sv - dot-product engine, one multiply-accumulate per cycle
//
// Computes sum(A[j]*B[j]) for j = 0..row-1 over two packed vectors of
// 32-bit elements. It captures the operands when a start is accepted and
// runs one MAC per clock. The full-precision result is returned with a
// busy/done handshake.
//
// Parameters:
//   row     elements per operand vector (>= 2)
//   SIGNED  1 = two's-complement operands, 0 = unsigned
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-low reset
//   MAC_opcode  start request (accepted in IDLE when Busy_A is low)
//   Busy_A      matrix A load in progress; blocks a start
//   Data_A      A vector, element j at bits [(j+1)*32-1 -: 32]
//   Data_B      B vector, same packing
//   Result      registered dot product, RW = 64+$clog2(row) bits
//   Busy_MAC    high while a computation is in progress
//   Done_MAC    one-cycle pulse when Result is updated
module matrix_mac #(
    parameter int row    = 4,
    parameter bit SIGNED = 1'b1,
    localparam int RW    = 64 + $clog2(row)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                MAC_opcode,
    input  logic                Busy_A,
    input  logic [row*32-1:0]   Data_A,
    input  logic [row*32-1:0]   Data_B,
    output logic [RW-1:0]       Result,
    output logic                Busy_MAC,
    output logic                Done_MAC
);

    localparam int IW = $clog2(row);
    localparam logic [IW-1:0] LAST_IDX = IW'(row - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [RW-1:0]       acc_q, acc_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [row*32-1:0]   a_q, a_d;
    logic [row*32-1:0]   b_q, b_d;
    logic [RW-1:0]       result_q, result_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [31:0]         a_el, b_el;
    logic [63:0]         a_ext, b_ext;
    logic [63:0]         prod;
    logic [RW-1:0]       prod_ext;
    logic [RW-1:0]       acc_sum;

    // Current element pair and its full-precision product. Extending both
    // operands to 64 bits first means a plain 64-bit multiply gives the
    // exact signed or unsigned product, since either always fits in 64 bits.
    always_comb begin
        a_el = a_q[{idx_q, 5'd0} +: 32];
        b_el = b_q[{idx_q, 5'd0} +: 32];
        if (SIGNED) begin
            a_ext = {{32{a_el[31]}}, a_el};
            b_ext = {{32{b_el[31]}}, b_el};
        end else begin
            a_ext = {32'd0, a_el};
            b_ext = {32'd0, b_el};
        end
        prod = a_ext * b_ext;
        if (SIGNED) begin
            prod_ext = {{(RW-64){prod[63]}}, prod};
        end else begin
            prod_ext = {{(RW-64){1'b0}}, prod};
        end
        acc_sum = acc_q + prod_ext;
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        idx_d    = idx_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                // A request seen while A is still loading is dropped, not queued.
                if (MAC_opcode && !Busy_A) begin
                    a_d     = Data_A;
                    b_d     = Data_B;
                    acc_d   = '0;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = acc_sum;
                idx_d = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    result_d = acc_sum;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    idx_d    = '0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign Result   = result_q;
    assign Busy_MAC = busy_q;
    assign Done_MAC = done_q;

endmodule

// File: tb/tb_matrix_mac.sv
// tb/tb_matrix_mac.sv - self-checking bench for matrix_mac (signed and unsigned instances)
module tb_matrix_mac;

    localparam int ROW = 4;
    localparam int RW  = 66;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic                MAC_opcode = 1'b0;
    logic                Busy_A = 1'b0;
    logic [ROW*32-1:0]   Data_A = '0;
    logic [ROW*32-1:0]   Data_B = '0;
    logic [RW-1:0]       result_s, result_u;
    logic                busy_s, busy_u, done_s, done_u;

    matrix_mac #(.row(ROW), .SIGNED(1'b1)) u_signed (
        .clk(clk), .reset(reset), .MAC_opcode(MAC_opcode), .Busy_A(Busy_A),
        .Data_A(Data_A), .Data_B(Data_B),
        .Result(result_s), .Busy_MAC(busy_s), .Done_MAC(done_s)
    );

    matrix_mac #(.row(ROW), .SIGNED(1'b0)) u_unsigned (
        .clk(clk), .reset(reset), .MAC_opcode(MAC_opcode), .Busy_A(Busy_A),
        .Data_A(Data_A), .Data_B(Data_B),
        .Result(result_u), .Busy_MAC(busy_u), .Done_MAC(done_u)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit started = 1'b0;

    task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [RW-1:0] dot(input logic [ROW*32-1:0] a, input logic [ROW*32-1:0] b,
                                          input bit sgn);
        logic [RW-1:0] s;
        longint sa, sb, p;
        longint unsigned ua, ub, up;
        s = '0;
        for (int j = 0; j < ROW; j++) begin
            if (sgn) begin
                sa = $signed(a[j*32 +: 32]);
                sb = $signed(b[j*32 +: 32]);
                p  = sa * sb;
                s  = s + {{2{p[63]}}, p};
            end else begin
                ua = a[j*32 +: 32];
                ub = b[j*32 +: 32];
                up = ua * ub;
                s  = s + {2'b00, up};
            end
        end
        return s;
    endfunction

    function automatic logic [ROW*32-1:0] pack(input logic [31:0] e0, input logic [31:0] e1,
                                               input logic [31:0] e2, input logic [31:0] e3);
        return {e3, e2, e1, e0};
    endfunction

    // Reference model: a start occupies the engine for ROW edges, the
    // result appears at the last of them, and the engine is free again
    // from the edge after.
    int            cyc = 0;
    int            fin_cyc = 0;
    bit            pending = 1'b0;
    logic [RW-1:0] pend_s = '0, pend_u = '0;
    logic [RW-1:0] m_res_s = '0, m_res_u = '0;
    bit            m_busy = 1'b0, m_done = 1'b0;

    task automatic model_clear();
        pending = 1'b0;
        m_res_s = '0;
        m_res_u = '0;
        m_busy  = 1'b0;
        m_done  = 1'b0;
    endtask

    always @(negedge reset) model_clear();

    always @(posedge clk) begin
        cyc++;
        if (!reset) begin
            model_clear();
        end else begin
            m_done = 1'b0;
            if (pending && cyc == fin_cyc) begin
                m_res_s = pend_s;
                m_res_u = pend_u;
                m_done  = 1'b1;
                pending = 1'b0;
            end else if (!pending && MAC_opcode && !Busy_A) begin
                pending = 1'b1;
                fin_cyc = cyc + ROW;
                pend_s  = dot(Data_A, Data_B, 1'b1);
                pend_u  = dot(Data_A, Data_B, 1'b0);
            end
            m_busy = pending;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("busy_s", RW'(busy_s), RW'(m_busy));
            chk("done_s", RW'(done_s), RW'(m_done));
            chk("result_s", result_s, m_res_s);
            chk("busy_u", RW'(busy_u), RW'(m_busy));
            chk("done_u", RW'(done_u), RW'(m_done));
            chk("result_u", result_u, m_res_u);
            checks++;
            if (busy_s && done_s) begin
                failures++;
                $display("FAIL busy_done_overlap: busy=1 done=1 at %0t", $time);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_pulse(input logic [ROW*32-1:0] a, input logic [ROW*32-1:0] b);
        Data_A = a;
        Data_B = b;
        MAC_opcode = 1'b1;
        step();
        MAC_opcode = 1'b0;
    endtask

    // Leaves the caller at the negedge where Done_MAC is high.
    task automatic wait_done(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!done_s && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_timeout"}, RW'(n < 20), RW'(1));
    endtask

    logic [ROW*32-1:0] va, vb, vc, vd;
    int nb, n;

    initial begin
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        started = 1'b1;
        chk("reset_result", result_s, '0);
        chk("reset_busy", RW'(busy_s), '0);
        chk("reset_done", RW'(done_s), '0);
        reset = 1'b1;
        step();

        // Basic dot product {1,2,3,4}.{5,6,7,8} = 70
        va = pack(1, 2, 3, 4);
        vb = pack(5, 6, 7, 8);
        chk("model_basic", dot(va, vb, 1'b1), RW'(70));
        start_pulse(va, vb);
        nb = 0;
        n = 0;
        @(negedge clk);
        while (!done_s && n < 20) begin
            if (busy_s) nb++;
            chk("basic_result_before_done", result_s, '0);
            @(negedge clk);
            n++;
        end
        chk("basic_busy_cycles", RW'(nb), RW'(4));
        chk("basic_result_s", result_s, RW'(70));
        chk("basic_result_u", result_u, RW'(70));
        step();

        // Sign extension: (-1)*2 summed four times
        va = pack(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
        vb = pack(2, 2, 2, 2);
        chk("model_sext_s", dot(va, vb, 1'b1), 66'h3_FFFF_FFFF_FFFF_FFF8);
        chk("model_sext_u", dot(va, vb, 1'b0), 66'h7_FFFF_FFF8);
        start_pulse(va, vb);
        wait_done("sext");
        chk("sext_result_s", result_s, 66'h3_FFFF_FFFF_FFFF_FFF8);
        chk("sext_result_u", result_u, 66'h7_FFFF_FFF8);
        step();

        // Widest positive operands: needs more than 64 bits of headroom
        va = pack(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF);
        chk("model_wide", dot(va, va, 1'b1), 66'h0_FFFF_FFFC_0000_0004);
        start_pulse(va, va);
        wait_done("wide");
        chk("wide_result_s", result_s, 66'h0_FFFF_FFFC_0000_0004);
        chk("wide_result_u", result_u, 66'h0_FFFF_FFFC_0000_0004);
        step();

        // Start gated by Busy_A, then accepted once Busy_A drops
        va = pack($urandom, $urandom, $urandom, $urandom);
        vb = pack($urandom, $urandom, $urandom, $urandom);
        Data_A = va;
        Data_B = vb;
        Busy_A = 1'b1;
        MAC_opcode = 1'b1;
        repeat (3) step();
        chk("gated_busy", RW'(busy_s), '0);
        Busy_A = 1'b0;
        step();
        chk("ungated_busy", RW'(busy_s), RW'(1));
        MAC_opcode = 1'b0;
        Data_A = ~va;
        Busy_A = 1'b1;
        step();
        MAC_opcode = 1'b1;
        step();
        MAC_opcode = 1'b0;
        Busy_A = 1'b0;
        wait_done("gated");
        chk("captured_result_s", result_s, dot(va, vb, 1'b1));
        chk("captured_result_u", result_u, dot(va, vb, 1'b0));
        step();

        // Back-to-back with opcode held; operands switched in the Done cycle
        va = pack($urandom, $urandom, $urandom, $urandom);
        vb = pack($urandom, $urandom, $urandom, $urandom);
        vc = pack($urandom, $urandom, $urandom, $urandom);
        vd = pack($urandom, $urandom, $urandom, $urandom);
        Data_A = va;
        Data_B = vb;
        MAC_opcode = 1'b1;
        wait_done("b2b_first");
        chk("b2b_first_s", result_s, dot(va, vb, 1'b1));
        Data_A = vc;
        Data_B = vd;
        @(negedge clk);
        chk("b2b_second_busy", RW'(busy_s), RW'(1));
        MAC_opcode = 1'b0;
        wait_done("b2b_second");
        chk("b2b_second_s", result_s, dot(vc, vd, 1'b1));
        chk("b2b_second_u", result_u, dot(vc, vd, 1'b0));
        step();

        // Asynchronous reset two cycles into RUN
        start_pulse(va, vb);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("async_busy", RW'(busy_s), '0);
        chk("async_result", result_s, '0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        step();
        start_pulse(vc, vb);
        wait_done("after_reset");
        chk("after_reset_s", result_s, dot(vc, vb, 1'b1));
        step();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            MAC_opcode = ($urandom_range(0, 1) == 1);
            Busy_A = ($urandom_range(0, 9) < 3);
            Data_A = pack($urandom, $urandom, $urandom, $urandom);
            Data_B = pack($urandom, $urandom, $urandom, $urandom);
            step();
        end
        MAC_opcode = 1'b0;
        Busy_A = 1'b0;
        repeat (8) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
